// File: rtl/cp0_pkg.sv
// Package: cp0_pkg
// Shared constants for the coprocessor-0 interrupt/exception controller:
// CP0 register numbers, SR/Cause bit positions, ExcCode values and the
// EPC computation used when an exception is taken.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IM_LSB  = 10;
  localparam int unsigned IP_LSB  = 10;
  localparam int unsigned BD_BIT  = 31;
  localparam int unsigned EXC_LSB = 2;

  localparam logic [4:0] INT  = 5'd0;
  localparam logic [4:0] ADEL = 5'd4;
  localparam logic [4:0] ADES = 5'd5;
  localparam logic [4:0] RI   = 5'd10;
  localparam logic [4:0] OV   = 5'd12;

  // A delay-slot instruction restarts at its branch, one word earlier.
  // The subtraction wraps modulo 2^32.
  function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] aligned;
    aligned = {pc[31:2], 2'b00};
    return bd ? (aligned - 32'd4) : aligned;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Module: irq_sync
// WIDTH-wide two-flop synchroniser for asynchronous interrupt lines.
// Only built when IRQ_SYNC_EN is defined; the default build has no use for it.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low reset (both flops clear to 0)
//   d     - asynchronous input lines
//   q     - synchronised lines (second flop)
`ifdef IRQ_SYNC_EN
module irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/cp0_irq_ctrl.sv
// Module: cp0_irq_ctrl
// Coprocessor-0 exception/interrupt controller for the pipelined MIPS core,
// sampled at the M stage. Holds SR, Cause, EPC and PRId, arbitrates external
// interrupts against synchronous exceptions, raises a combinational
// flush/redirect request, and services mfc0, mtc0 and eret.
// Build option: IRQ_SYNC_EN - when defined, hw_int passes through a two-flop
//   synchroniser (irq_sync) before use, adding two cycles of latency.
// Ports:
//   clk, reset           - clock, synchronous active-low reset
//   hw_int[NUM_IRQ]      - level-sensitive device interrupt lines
//   pc_m, bd_m           - PC and delay-slot flag of the M instruction
//   exc_valid_m, exc_code_m - synchronous exception from M and its ExcCode
//   eret_m               - eret in M
//   we, addr, wdata      - mtc0 write strobe, CP0 register number, data
//   rdata                - mfc0 read data (combinational from addr)
//   req, exc_pc          - flush/redirect request and redirect target
//   epc_out              - current EPC
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0001,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] hw_int,
  input  logic [31:0]        pc_m,
  input  logic               bd_m,
  input  logic               exc_valid_m,
  input  logic [4:0]         exc_code_m,
  input  logic               eret_m,
  input  logic               we,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               req,
  output logic [31:0]        exc_pc,
  output logic [31:0]        epc_out
);

  logic [NUM_IRQ-1:0] hw_int_eff;

`ifdef IRQ_SYNC_EN
  irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hw_int),
    .q     (hw_int_eff)
  );
`else
  assign hw_int_eff = hw_int;
`endif

  logic               sr_ie;
  logic               sr_exl;
  logic [NUM_IRQ-1:0] sr_im;
  logic [4:0]         cause_exc;
  logic [NUM_IRQ-1:0] cause_ip;
  logic               cause_bd;
  logic [31:0]        epc;

  logic int_req;
  logic ex_req;
  logic sr_wr;
  logic epc_wr;

  // Interrupts look at the live lines, not the registered IP copy, so a
  // line edge can take effect in the same cycle.
  assign int_req = (|(hw_int_eff & sr_im)) & sr_ie & ~sr_exl;
  assign ex_req  = exc_valid_m & ~sr_exl;
  assign req     = int_req | ex_req;

  assign sr_wr  = we && (addr == CP0_SR);
  assign epc_wr = we && (addr == CP0_EPC);

  // The req/eret updates come after the mtc0 updates so they override EXL
  // and EPC, while IE/IM from a same-cycle SR write still land.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_ie     <= 1'b0;
      sr_exl    <= 1'b0;
      sr_im     <= '0;
      cause_exc <= 5'd0;
      cause_ip  <= '0;
      cause_bd  <= 1'b0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= hw_int_eff;

      if (sr_wr) begin
        sr_ie  <= wdata[IE_BIT];
        sr_exl <= wdata[EXL_BIT];
        sr_im  <= wdata[IM_LSB +: NUM_IRQ];
      end
      if (epc_wr) begin
        epc <= {wdata[31:2], 2'b00};
      end

      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? INT : exc_code_m;
        cause_bd  <= bd_m;
        epc       <= calc_epc(pc_m, bd_m);
      end else if (eret_m) begin
        sr_exl <= 1'b0;
      end
    end
  end

  logic [31:0] sr_word;
  logic [31:0] cause_word;

  always_comb begin
    sr_word                     = 32'd0;
    sr_word[IE_BIT]             = sr_ie;
    sr_word[EXL_BIT]            = sr_exl;
    sr_word[IM_LSB +: NUM_IRQ]  = sr_im;

    cause_word                    = 32'd0;
    cause_word[EXC_LSB +: 5]      = cause_exc;
    cause_word[IP_LSB +: NUM_IRQ] = cause_ip;
    cause_word[BD_BIT]            = cause_bd;
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      CP0_SR:    rdata = sr_word;
      CP0_CAUSE: rdata = cause_word;
      CP0_EPC:   rdata = epc;
      CP0_PRID:  rdata = PRID_VAL;
      default:   rdata = 32'd0;
    endcase
  end

  always_comb begin
    exc_pc = 32'd0;
    if (req) begin
      exc_pc = HANDLER_PC;
    end else if (eret_m) begin
      exc_pc = epc;
    end
  end

  assign epc_out = epc;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Testbench for cp0_irq_ctrl. Each table row is one clock cycle: inputs
// driven just after the rising edge, outputs expected mid-cycle (before the
// next edge updates the registers). Expectations are queued when a row is
// driven and popped when the outputs are sampled.
module tb_cp0_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] exc_pc;
  logic [31:0] epc_out;

  always #5 clk = ~clk;

  cp0_irq_ctrl #(
    .NUM_IRQ    (6),
    .PRID_VAL   (32'h0000_0001),
    .HANDLER_PC (32'h0000_4180)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hw_int      (hw_int),
    .pc_m        (pc_m),
    .bd_m        (bd_m),
    .exc_valid_m (exc_valid_m),
    .exc_code_m  (exc_code_m),
    .eret_m      (eret_m),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .req         (req),
    .exc_pc      (exc_pc),
    .epc_out     (epc_out)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  hw;
    logic [31:0] pc;
    logic        bd;
    logic        ev;
    logic [4:0]  code;
    logic        eret;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        x_req;
    logic [31:0] x_pc;
    logic [31:0] x_rd;
    logic [31:0] x_epc;
  } vec_t;

  typedef struct {
    string       name;
    logic        req;
    logic [31:0] xpc;
    logic [31:0] rd;
    logic [31:0] epc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string n, input logic rst, input logic [5:0] hw,
                              input logic [31:0] pc, input logic bd, input logic ev,
                              input logic [4:0] code, input logic eret, input logic w,
                              input logic [4:0] a, input logic [31:0] wd,
                              input logic rq, input logic [31:0] xpc,
                              input logic [31:0] rd, input logic [31:0] ep);
    vec_t v;
    v.name = n;  v.rst = rst; v.hw = hw; v.pc = pc; v.bd = bd; v.ev = ev;
    v.code = code; v.eret = eret; v.we = w; v.addr = a; v.wd = wd;
    v.x_req = rq; v.x_pc = xpc; v.x_rd = rd; v.x_epc = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    reset       = v.rst;
    hw_int      = v.hw;
    pc_m        = v.pc;
    bd_m        = v.bd;
    exc_valid_m = v.ev;
    exc_code_m  = v.code;
    eret_m      = v.eret;
    we          = v.we;
    addr        = v.addr;
    wdata       = v.wd;
    e.name = v.name; e.req = v.x_req; e.xpc = v.x_pc; e.rd = v.x_rd; e.epc = v.x_epc;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".req"},     {31'd0, req}, {31'd0, e.req});
      chk({e.name, ".exc_pc"},  exc_pc,       e.xpc);
      chk({e.name, ".rdata"},   rdata,        e.rd);
      chk({e.name, ".epc_out"}, epc_out,      e.epc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; hw_int = '0; pc_m = '0; bd_m = 1'b0; exc_valid_m = 1'b0;
    exc_code_m = '0; eret_m = 1'b0; we = 1'b0; addr = 5'd12; wdata = '0;
    @(posedge clk); #1;

    //            name             rst hw     pc            bd ev code  er we addr   wdata          req xpc           rdata         epc
    tbl.push_back(mk("rst_hold",    0, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h0,        32'h0));
`ifndef IRQ_SYNC_EN
    tbl.push_back(mk("rd_sr",       1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("rd_cause",    1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("rd_epc",      1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd14, 32'h0,          0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("rd_prid",     1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd15, 32'h0,          0, 32'h0,        32'h1,        32'h0));
    tbl.push_back(mk("rd_unmapped", 1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd16, 32'h0,          0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("wr_sr",       1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 1, 5'd12, 32'h401,        0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("irq_raise",   1, 6'h01, 32'h3010,     0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          1, 32'h4180,     32'h401,      32'h0));
    tbl.push_back(mk("irq_exl",     1, 6'h01, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h403,      32'h3010));
    tbl.push_back(mk("irq_cause",   1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h400,      32'h3010));
    tbl.push_back(mk("eret1",       1, 6'h00, 32'h0,        0, 0, 5'd0, 1, 0, 5'd14, 32'h0,          0, 32'h3010,     32'h3010,     32'h3010));
    tbl.push_back(mk("sr_eret1",    1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h401,      32'h3010));
    tbl.push_back(mk("dslot_exc",   1, 6'h00, 32'h3024,     1, 1, 5'd12,0, 0, 5'd13, 32'h0,          1, 32'h4180,     32'h0,        32'h3010));
    tbl.push_back(mk("dslot_cause", 1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h8000_0030,32'h3020));
    tbl.push_back(mk("mask_exl",    1, 6'h3f, 32'h5000,     0, 1, 5'd5, 0, 0, 5'd14, 32'h0,          0, 32'h0,        32'h3020,     32'h3020));
    tbl.push_back(mk("mask_ip",     1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h8000_fc30,32'h3020));
    tbl.push_back(mk("eret_wr_sr",  1, 6'h00, 32'h0,        0, 0, 5'd0, 1, 1, 5'd12, 32'h1003,       0, 32'h3020,     32'h403,      32'h3020));
    tbl.push_back(mk("sr_im2",      1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h1001,     32'h3020));
    tbl.push_back(mk("collide",     1, 6'h04, 32'h3040,     0, 1, 5'd4, 0, 0, 5'd13, 32'h0,          1, 32'h4180,     32'h8000_0030,32'h3020));
    tbl.push_back(mk("coll_cause",  1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h1000,     32'h3040));
    tbl.push_back(mk("eret2",       1, 6'h00, 32'h0,        0, 0, 5'd0, 1, 0, 5'd12, 32'h0,          0, 32'h3040,     32'h1003,     32'h3040));
    tbl.push_back(mk("sr_open",     1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h1001,     32'h3040));
    tbl.push_back(mk("wr_sr_ie0",   1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 1, 5'd12, 32'hfc00,       0, 32'h0,        32'h1001,     32'h3040));
    tbl.push_back(mk("ie0_mask",    1, 6'h3f, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h0,        32'h3040));
    tbl.push_back(mk("ie0_ip",      1, 6'h3f, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'hfc00,     32'h3040));
    tbl.push_back(mk("wr_epc",      1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 1, 5'd14, 32'h1234_567b,  0, 32'h0,        32'h3040,     32'h3040));
    tbl.push_back(mk("rd_epc_wr",   1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd14, 32'h0,          0, 32'h0,        32'h1234_5678,32'h1234_5678));
    tbl.push_back(mk("wr_cause",    1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 1, 5'd13, 32'hffff_ffff,  0, 32'h0,        32'h0,        32'h1234_5678));
    tbl.push_back(mk("cause_ro",    1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h0,        32'h1234_5678));
    tbl.push_back(mk("wr_prid",     1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 1, 5'd15, 32'h0,          0, 32'h0,        32'h1,        32'h1234_5678));
    tbl.push_back(mk("prid_ro",     1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd15, 32'h0,          0, 32'h0,        32'h1,        32'h1234_5678));
    tbl.push_back(mk("req_wr_sr",   1, 6'h00, 32'h3,        1, 1, 5'd10,0, 1, 5'd12, 32'h401,        1, 32'h4180,     32'hfc00,     32'h1234_5678));
    tbl.push_back(mk("sr_req_win",  1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h403,      32'hffff_fffc));
    tbl.push_back(mk("wrap_cause",  1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h8000_0028,32'hffff_fffc));
    tbl.push_back(mk("eret3",       1, 6'h00, 32'h0,        0, 0, 5'd0, 1, 0, 5'd14, 32'h0,          0, 32'hffff_fffc,32'hffff_fffc,32'hffff_fffc));
    tbl.push_back(mk("req_wr_epc",  1, 6'h01, 32'h2008,     0, 0, 5'd0, 0, 1, 5'd14, 32'haaaa_aaa8,  1, 32'h4180,     32'hffff_fffc,32'hffff_fffc));
    tbl.push_back(mk("epc_req_win", 1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd14, 32'h0,          0, 32'h0,        32'h2008,     32'h2008));
    tbl.push_back(mk("rst_mid",     0, 6'h01, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h403,      32'h2008));
    tbl.push_back(mk("post_rst",    1, 6'h01, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("post_rst_ip", 1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h400,      32'h0));
`else
    // Synchroniser latency: hw_int[5] rises in s_t0, req first high two cycles later.
    tbl.push_back(mk("s_wr_sr",     1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 1, 5'd12, 32'h8001,       0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("s_t0",        1, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h8001,     32'h0));
    tbl.push_back(mk("s_t1",        1, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h8001,     32'h0));
    tbl.push_back(mk("s_t2",        1, 6'h20, 32'h3100,     0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          1, 32'h4180,     32'h8001,     32'h0));
    tbl.push_back(mk("s_exl",       1, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h8003,     32'h3100));
    tbl.push_back(mk("s_rst",       0, 6'h00, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h8003,     32'h3100));
    tbl.push_back(mk("s_wr_sr2",    1, 6'h00, 32'h0,        0, 0, 5'd0, 0, 1, 5'd12, 32'h8001,       0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("s_r_t0",      1, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h8001,     32'h0));
    tbl.push_back(mk("s_r_t1",      0, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h8001,     32'h0));
    tbl.push_back(mk("s_r_t2",      1, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd12, 32'h0,          0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("s_r_t3",      1, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("s_r_t4",      1, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk("s_r_t5",      1, 6'h20, 32'h0,        0, 0, 5'd0, 0, 0, 5'd13, 32'h0,          0, 32'h0,        32'h8000,     32'h0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      check_pop();
      @(posedge clk); #1;
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
